// File: rtl/warp_issue_pkg.sv
// Shared definitions for the warp issue stage.
// Bundle layout, LSB first: legal, rs1, rs2, rd, rd_en, pipe_mask, ctrl.
// The offset helpers take NREG/NPIPE/CTRL_W so any configuration derives
// its own layout. The port indices below describe the standard unit map.
package warp_issue_pkg;

  // Register-address width; at least one bit even for a single register.
  function automatic int unsigned ra_w(input int unsigned nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  function automatic int unsigned off_rs1(input int unsigned nreg);
    return 1;
  endfunction

  function automatic int unsigned off_rs2(input int unsigned nreg);
    return 1 + ra_w(nreg);
  endfunction

  function automatic int unsigned off_rd(input int unsigned nreg);
    return 1 + 2 * ra_w(nreg);
  endfunction

  function automatic int unsigned off_rd_en(input int unsigned nreg);
    return 1 + 3 * ra_w(nreg);
  endfunction

  function automatic int unsigned off_mask(input int unsigned nreg);
    return 2 + 3 * ra_w(nreg);
  endfunction

  function automatic int unsigned off_ctrl(input int unsigned nreg, input int unsigned npipe);
    return 2 + 3 * ra_w(nreg) + npipe;
  endfunction

  function automatic int unsigned bundle_w(input int unsigned nreg, input int unsigned npipe,
                                           input int unsigned ctrl_w);
    return off_ctrl(nreg, npipe) + ctrl_w;
  endfunction

  // Standard functional-unit port map.
  localparam int unsigned XARITH0 = 0;
  localparam int unsigned XARITH1 = 1;
  localparam int unsigned XLOGIC0 = 2;
  localparam int unsigned XLOGIC1 = 3;
  localparam int unsigned XSHIFT  = 4;
  localparam int unsigned XMULTL  = 5;
  localparam int unsigned XMULTH  = 6;
  localparam int unsigned XDIV    = 7;

endpackage

// File: rtl/warp_issue_pick.sv
// Masked lowest-index ready-port priority encoder.
// Ports:
//   mask   - ports the bundle is eligible for
//   ready  - per-port ready from the functional units
//   excl   - ports already granted to an older bundle this cycle
//   grant  - one-hot selected port (all zero when none is available)
//   found  - a port was selected
module warp_issue_pick
  import warp_issue_pkg::*;
#(
  parameter int unsigned NPIPE = 8
) (
  input  logic [NPIPE-1:0] mask,
  input  logic [NPIPE-1:0] ready,
  input  logic [NPIPE-1:0] excl,
  output logic [NPIPE-1:0] grant,
  output logic             found
);

  logic [NPIPE-1:0] req;

  // Isolate the lowest set bit with req & -req.
  always_comb begin
    req   = mask & ready & ~excl;
    grant = req & (~req + NPIPE'(1));
    found = |req;
  end

endmodule

// File: rtl/warp_issue_sb.sv
// Two-slot in-order dual-issue stage with a register scoreboard.
// Buffers a decoded bundle pair, checks operands/destination against the
// scoreboard (with same-cycle write-back bypass), and dispatches up to two
// bundles per clock to NPIPE generic unit ports chosen from each bundle's
// eligible-port mask.
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_flush                    drop buffered bundles (scoreboard kept)
//   o_input_ready, i_input_valid, i_bundle0/1   bundle-pair input
//   o_pipe_valid/ctrl/rd, i_pipe_ready          per-port dispatch
//   o_rs_addr                  {s1.rs2, s1.rs1, s0.rs2, s0.rs1}
//   i_wb_valid, i_wb_rd        write-back scoreboard clears
//   o_trap                     illegal bundle at head
//   o_busy_regs                scoreboard state
// Optional: define WARP_ISSUE_PERF_EN for o_perf_dual/single/stall counters.
module warp_issue_sb
  import warp_issue_pkg::*;
#(
  parameter  int unsigned NREG     = 32,
  parameter  int unsigned NPIPE    = 8,
  parameter  int unsigned NWB      = 2,
  parameter  int unsigned CTRL_W   = 16,
  localparam int unsigned RA_W     = ra_w(NREG),
  localparam int unsigned BUNDLE_W = bundle_w(NREG, NPIPE, CTRL_W)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  output logic                    o_input_ready,
  input  logic                    i_input_valid,
  input  logic [BUNDLE_W-1:0]     i_bundle0,
  input  logic [BUNDLE_W-1:0]     i_bundle1,
  output logic [NPIPE-1:0]        o_pipe_valid,
  input  logic [NPIPE-1:0]        i_pipe_ready,
  output logic [NPIPE*CTRL_W-1:0] o_pipe_ctrl,
  output logic [NPIPE*RA_W-1:0]   o_pipe_rd,
  output logic [4*RA_W-1:0]       o_rs_addr,
  input  logic [NWB-1:0]          i_wb_valid,
  input  logic [NWB*RA_W-1:0]     i_wb_rd,
  output logic                    o_trap,
`ifdef WARP_ISSUE_PERF_EN
  output logic [31:0]             o_perf_dual,
  output logic [31:0]             o_perf_single,
  output logic [31:0]             o_perf_stall,
`endif
  output logic [NREG-1:0]         o_busy_regs
);

  localparam int unsigned O_RS1  = off_rs1(NREG);
  localparam int unsigned O_RS2  = off_rs2(NREG);
  localparam int unsigned O_RD   = off_rd(NREG);
  localparam int unsigned O_RDEN = off_rd_en(NREG);
  localparam int unsigned O_MASK = off_mask(NREG);
  localparam int unsigned O_CTRL = off_ctrl(NREG, NPIPE);

  logic [BUNDLE_W-1:0] slot0_q, slot1_q, slot0_d, slot1_d;
  logic                v0_q, v1_q, v0_d, v1_d;
  logic [NREG-1:0]     sb_q, sb_d, sb_set, wb_clr, eff_busy;

  // Slot field views.
  logic              h_legal, s_legal, h_rd_en, s_rd_en;
  logic [RA_W-1:0]   h_rs1, h_rs2, h_rd, s_rs1, s_rs2, s_rd;
  logic [NPIPE-1:0]  h_mask, s_mask;
  logic [CTRL_W-1:0] h_ctrl, s_ctrl;

  always_comb begin
    h_legal = slot0_q[0];
    h_rs1   = slot0_q[O_RS1 +: RA_W];
    h_rs2   = slot0_q[O_RS2 +: RA_W];
    h_rd    = slot0_q[O_RD +: RA_W];
    h_rd_en = slot0_q[O_RDEN];
    h_mask  = slot0_q[O_MASK +: NPIPE];
    h_ctrl  = slot0_q[O_CTRL +: CTRL_W];
    s_legal = slot1_q[0];
    s_rs1   = slot1_q[O_RS1 +: RA_W];
    s_rs2   = slot1_q[O_RS2 +: RA_W];
    s_rd    = slot1_q[O_RD +: RA_W];
    s_rd_en = slot1_q[O_RDEN];
    s_mask  = slot1_q[O_MASK +: NPIPE];
    s_ctrl  = slot1_q[O_CTRL +: CTRL_W];
  end

  // Write-back clears are visible to the issue checks in the same cycle.
  always_comb begin
    wb_clr = '0;
    for (int w = 0; w < NWB; w++) begin
      if (i_wb_valid[w]) wb_clr[i_wb_rd[w*RA_W +: RA_W]] = 1'b1;
    end
    eff_busy = sb_q & ~wb_clr;
  end

  logic [NPIPE-1:0] h_grant, s_grant, h_sel, s_sel;
  logic             h_found, s_found;

  warp_issue_pick #(.NPIPE(NPIPE)) u_pick_head (
    .mask  (h_mask),
    .ready (i_pipe_ready),
    .excl  ({NPIPE{1'b0}}),
    .grant (h_grant),
    .found (h_found)
  );

  warp_issue_pick #(.NPIPE(NPIPE)) u_pick_second (
    .mask  (s_mask),
    .ready (i_pipe_ready),
    .excl  (h_grant),
    .grant (s_grant),
    .found (s_found)
  );

  // An empty pipe_mask is a decoder-inserted no-op: needs no port, reserves nothing.
  logic h_nop, s_nop, h_res, s_res, h_clear, s_clear, h_go, s_go;

  always_comb begin
    h_nop   = (h_mask == '0);
    s_nop   = (s_mask == '0);
    h_res   = h_rd_en && (h_rd != '0) && !h_nop;
    s_res   = s_rd_en && (s_rd != '0) && !s_nop;
    h_clear = !eff_busy[h_rs1] && !eff_busy[h_rs2] && !(h_res && eff_busy[h_rd]);
    s_clear = !eff_busy[s_rs1] && !eff_busy[s_rs2] && !(s_res && eff_busy[s_rd])
              && !(h_res && ((s_rs1 == h_rd) || (s_rs2 == h_rd) || (s_res && (s_rd == h_rd))));
    h_go    = v0_q && h_legal && !i_flush && (h_nop || (h_clear && h_found));
    s_go    = h_go && v1_q && s_legal && (s_nop || (s_clear && s_found));
    h_sel   = h_go ? h_grant : '0;
    s_sel   = s_go ? s_grant : '0;
  end

  // Dispatch outputs; idle ports drive zero.
  always_comb begin
    o_pipe_valid = h_sel | s_sel;
    o_pipe_ctrl  = '0;
    o_pipe_rd    = '0;
    for (int p = 0; p < NPIPE; p++) begin
      if (h_sel[p]) begin
        o_pipe_ctrl[p*CTRL_W +: CTRL_W] = h_ctrl;
        o_pipe_rd[p*RA_W +: RA_W]       = h_rd;
      end else if (s_sel[p]) begin
        o_pipe_ctrl[p*CTRL_W +: CTRL_W] = s_ctrl;
        o_pipe_rd[p*RA_W +: RA_W]       = s_rd;
      end
    end
  end

  always_comb begin
    o_rs_addr = {v1_q ? s_rs2 : RA_W'(0), v1_q ? s_rs1 : RA_W'(0),
                 v0_q ? h_rs2 : RA_W'(0), v0_q ? h_rs1 : RA_W'(0)};
    o_trap      = v0_q && !h_legal;
    o_busy_regs = sb_q;
  end

  // Slot 1 is only ever occupied alongside slot 0.
  always_comb begin
    o_input_ready = !i_flush && ((!v0_q) || (v1_q && s_go) || (!v1_q && h_go));
  end

  // Slot and scoreboard next state; a set beats a same-cycle clear.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sb_set  = '0;
    if (h_go && h_res) sb_set[h_rd] = 1'b1;
    if (s_go && s_res) sb_set[s_rd] = 1'b1;
    sb_d = eff_busy | sb_set;
    if (i_flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (i_input_valid && o_input_ready) begin
      slot0_d = i_bundle0;
      slot1_d = i_bundle1;
      v0_d    = 1'b1;
      v1_d    = 1'b1;
    end else if (s_go) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (h_go) begin
      slot0_d = slot1_q;
      v0_d    = v1_q;
      v1_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      sb_q    <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sb_q    <= sb_d;
    end
  end

`ifdef WARP_ISSUE_PERF_EN
  // Saturating dispatch statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_dual   <= '0;
      o_perf_single <= '0;
      o_perf_stall  <= '0;
    end else begin
      if (s_go && (o_perf_dual != '1))            o_perf_dual   <= o_perf_dual + 32'(1);
      if (h_go && !s_go && (o_perf_single != '1)) o_perf_single <= o_perf_single + 32'(1);
      if (v0_q && !h_go && (o_perf_stall != '1))  o_perf_stall  <= o_perf_stall + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_warp_issue_sb.sv
// Directed self-checking bench for warp_issue_sb (default parameters).
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
module tb_warp_issue_sb;

  localparam int unsigned RA_W = 5;
  localparam int unsigned BW   = 41;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_flush;
  logic          o_input_ready;
  logic          i_input_valid;
  logic [BW-1:0] i_bundle0, i_bundle1;
  logic [7:0]    o_pipe_valid;
  logic [7:0]    i_pipe_ready;
  logic [127:0]  o_pipe_ctrl;
  logic [39:0]   o_pipe_rd;
  logic [19:0]   o_rs_addr;
  logic [1:0]    i_wb_valid;
  logic [9:0]    i_wb_rd;
  logic          o_trap;
  logic [31:0]   o_busy_regs;
`ifdef WARP_ISSUE_PERF_EN
  logic [31:0]   o_perf_dual, o_perf_single, o_perf_stall;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 i_clk = ~i_clk;

  warp_issue_sb dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .o_input_ready (o_input_ready),
    .i_input_valid (i_input_valid),
    .i_bundle0     (i_bundle0),
    .i_bundle1     (i_bundle1),
    .o_pipe_valid  (o_pipe_valid),
    .i_pipe_ready  (i_pipe_ready),
    .o_pipe_ctrl   (o_pipe_ctrl),
    .o_pipe_rd     (o_pipe_rd),
    .o_rs_addr     (o_rs_addr),
    .i_wb_valid    (i_wb_valid),
    .i_wb_rd       (i_wb_rd),
    .o_trap        (o_trap),
`ifdef WARP_ISSUE_PERF_EN
    .o_perf_dual   (o_perf_dual),
    .o_perf_single (o_perf_single),
    .o_perf_stall  (o_perf_stall),
`endif
    .o_busy_regs   (o_busy_regs)
  );

  function automatic logic [BW-1:0] mk(input logic legal, input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic rd_en, input logic [7:0] mask,
                                       input logic [15:0] ctrl);
    return {ctrl, mask, rd_en, rd, rs2, rs1, legal};
  endfunction

  function automatic logic [BW-1:0] nop();
    return mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 8'h00, 16'h0000);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic load(input logic [BW-1:0] b0, input logic [BW-1:0] b1);
    i_bundle0 = b0;
    i_bundle1 = b1;
    i_input_valid = 1'b1;
    tick();
    i_input_valid = 1'b0;
  endtask

  task automatic wb1(input logic [4:0] rd);
    i_wb_valid = 2'b01;
    i_wb_rd = {5'd0, rd};
  endtask

  task automatic wb_off();
    i_wb_valid = 2'b00;
    i_wb_rd = '0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_input_valid = 1'b0;
    i_bundle0 = '0;
    i_bundle1 = '0;
    i_pipe_ready = 8'hFF;
    i_wb_valid = '0;
    i_wb_rd = '0;
    #13;
    n_total++;
    if (o_pipe_valid !== 8'h00 || o_trap !== 1'b0 || o_input_ready !== 1'b1 || o_busy_regs !== 32'h0)
      $display("FAIL reset_outputs: valid=%h trap=%b ready=%b busy=%h, want 00/0/1/00000000",
               o_pipe_valid, o_trap, o_input_ready, o_busy_regs);
    else n_pass++;
    n_total++;
    if (o_pipe_ctrl !== '0 || o_pipe_rd !== '0 || o_rs_addr !== '0)
      $display("FAIL reset_data: ctrl=%h rd=%h rs=%h, want all zero", o_pipe_ctrl, o_pipe_rd, o_rs_addr);
    else n_pass++;
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_dual();
    load(mk(1, 5'd2, 5'd0, 5'd1, 1, 8'h01, 16'hA001), mk(1, 5'd4, 5'd0, 5'd3, 1, 8'h03, 16'hB003));
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h03) $display("FAIL dual_valid: got %h want 03", o_pipe_valid);
    else n_pass++;
    n_total++;
    if (o_pipe_ctrl[15:0] !== 16'hA001 || o_pipe_ctrl[31:16] !== 16'hB003 ||
        o_pipe_rd[4:0] !== 5'd1 || o_pipe_rd[9:5] !== 5'd3)
      $display("FAIL dual_payload: ctrl0=%h ctrl1=%h rd0=%0d rd1=%0d want a001 b003 1 3",
               o_pipe_ctrl[15:0], o_pipe_ctrl[31:16], o_pipe_rd[4:0], o_pipe_rd[9:5]);
    else n_pass++;
    n_total++;
    if (o_rs_addr !== {5'd0, 5'd4, 5'd0, 5'd2}) $display("FAIL dual_rs_addr: got %h want %h", o_rs_addr, {5'd0, 5'd4, 5'd0, 5'd2});
    else n_pass++;
    n_total++;
    if (o_input_ready !== 1'b1) $display("FAIL dual_input_ready: got %b want 1", o_input_ready);
    else n_pass++;
    tick();
    n_total++;
    if (o_busy_regs !== 32'h0000_000A || o_pipe_valid !== 8'h00)
      $display("FAIL dual_busy: busy=%h valid=%h want 0000000a 00", o_busy_regs, o_pipe_valid);
    else n_pass++;
    i_wb_valid = 2'b11;
    i_wb_rd = {5'd3, 5'd1};
    tick();
    wb_off();
    n_total++;
    if (o_busy_regs !== 32'h0) $display("FAIL dual_wb_clear: busy=%h want 00000000", o_busy_regs);
    else n_pass++;
  endtask

  task automatic test_wb_bypass();
    load(mk(1, 5'd6, 5'd0, 5'd5, 1, 8'h01, 16'h0005), mk(1, 5'd5, 5'd0, 5'd7, 1, 8'h02, 16'h0007));
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h01 || o_input_ready !== 1'b0)
      $display("FAIL raw_pair_head_only: valid=%h ready=%b want 01 0", o_pipe_valid, o_input_ready);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h00 || o_busy_regs !== 32'h0000_0020)
      $display("FAIL raw_shift_stall: valid=%h busy=%h want 00 00000020", o_pipe_valid, o_busy_regs);
    else n_pass++;
    wb1(5'd5);
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h02 || o_input_ready !== 1'b1 || o_pipe_ctrl[31:16] !== 16'h0007)
      $display("FAIL wb_bypass_issue: valid=%h ready=%b ctrl1=%h want 02 1 0007",
               o_pipe_valid, o_input_ready, o_pipe_ctrl[31:16]);
    else n_pass++;
    tick();
    wb_off();
    n_total++;
    if (o_busy_regs !== 32'h0000_0080) $display("FAIL wb_bypass_busy: busy=%h want 00000080", o_busy_regs);
    else n_pass++;
    wb1(5'd7);
    tick();
    wb_off();
  endtask

  task automatic test_same_port();
    load(mk(1, 5'd0, 5'd0, 5'd0, 0, 8'h10, 16'h1111), mk(1, 5'd0, 5'd0, 5'd0, 0, 8'h10, 16'h2222));
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h10 || o_pipe_ctrl[79:64] !== 16'h1111)
      $display("FAIL shift_port_first: valid=%h ctrl4=%h want 10 1111", o_pipe_valid, o_pipe_ctrl[79:64]);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h10 || o_pipe_ctrl[79:64] !== 16'h2222)
      $display("FAIL shift_port_second: valid=%h ctrl4=%h want 10 2222", o_pipe_valid, o_pipe_ctrl[79:64]);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h00 || o_input_ready !== 1'b1)
      $display("FAIL shift_port_drain: valid=%h ready=%b want 00 1", o_pipe_valid, o_input_ready);
    else n_pass++;
  endtask

  task automatic test_busy_stall();
    load(mk(1, 5'd0, 5'd0, 5'd9, 1, 8'h01, 16'h0009), nop());
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h01 || o_input_ready !== 1'b1)
      $display("FAIL nop_pair_issue: valid=%h ready=%b want 01 1", o_pipe_valid, o_input_ready);
    else n_pass++;
    tick();
    load(mk(1, 5'd9, 5'd0, 5'd10, 1, 8'h04, 16'h000A), nop());
    for (int c = 0; c < 10; c++) begin
      #1;
      n_total++;
      if (o_pipe_valid !== 8'h00 || o_input_ready !== 1'b0 || o_busy_regs !== 32'h0000_0200)
        $display("FAIL busy_stall_c%0d: valid=%h ready=%b busy=%h want 00 0 00000200",
                 c, o_pipe_valid, o_input_ready, o_busy_regs);
      else n_pass++;
      tick();
    end
    wb1(5'd9);
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h04 || o_input_ready !== 1'b1)
      $display("FAIL busy_release: valid=%h ready=%b want 04 1", o_pipe_valid, o_input_ready);
    else n_pass++;
    tick();
    wb_off();
    n_total++;
    if (o_busy_regs !== 32'h0000_0400) $display("FAIL busy_release_sb: busy=%h want 00000400", o_busy_regs);
    else n_pass++;
    wb1(5'd10);
    tick();
    wb_off();
  endtask

  task automatic test_trap_flush();
    load(mk(0, 5'd0, 5'd0, 5'd0, 0, 8'h01, 16'hDEAD), nop());
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if (o_trap !== 1'b1 || o_pipe_valid !== 8'h00 || o_input_ready !== 1'b0)
        $display("FAIL trap_hold_c%0d: trap=%b valid=%h ready=%b want 1 00 0",
                 c, o_trap, o_pipe_valid, o_input_ready);
      else n_pass++;
      tick();
    end
    i_flush = 1'b1;
    i_bundle0 = mk(1, 5'd0, 5'd0, 5'd11, 1, 8'h01, 16'h0BAD);
    i_input_valid = 1'b1;
    #1;
    n_total++;
    if (o_input_ready !== 1'b0 || o_pipe_valid !== 8'h00)
      $display("FAIL flush_cycle: ready=%b valid=%h want 0 00", o_input_ready, o_pipe_valid);
    else n_pass++;
    tick();
    i_flush = 1'b0;
    i_input_valid = 1'b0;
    #1;
    n_total++;
    if (o_trap !== 1'b0 || o_input_ready !== 1'b1 || o_pipe_valid !== 8'h00 || o_busy_regs !== 32'h0)
      $display("FAIL flush_after: trap=%b ready=%b valid=%h busy=%h want 0 1 00 00000000",
               o_trap, o_input_ready, o_pipe_valid, o_busy_regs);
    else n_pass++;
  endtask

  task automatic test_set_wins();
    load(mk(1, 5'd0, 5'd0, 5'd3, 1, 8'h01, 16'h0003), nop());
    tick();
    load(mk(1, 5'd0, 5'd0, 5'd3, 1, 8'h08, 16'h0033), nop());
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h00 || o_busy_regs !== 32'h0000_0008)
      $display("FAIL waw_block: valid=%h busy=%h want 00 00000008", o_pipe_valid, o_busy_regs);
    else n_pass++;
    wb1(5'd3);
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h08 || o_pipe_rd[19:15] !== 5'd3)
      $display("FAIL waw_release: valid=%h rd3=%0d want 08 3", o_pipe_valid, o_pipe_rd[19:15]);
    else n_pass++;
    tick();
    wb_off();
    n_total++;
    if (o_busy_regs !== 32'h0000_0008) $display("FAIL set_wins: busy=%h want 00000008", o_busy_regs);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    load(mk(1, 5'd3, 5'd0, 5'd12, 1, 8'h01, 16'h000C), nop());
    #1;
    n_total++;
    if (o_pipe_valid !== 8'h00 || o_input_ready !== 1'b0)
      $display("FAIL pre_reset_stall: valid=%h ready=%b want 00 0", o_pipe_valid, o_input_ready);
    else n_pass++;
    i_rst_n = 1'b0;
    #1;
    n_total++;
    if (o_busy_regs !== 32'h0 || o_input_ready !== 1'b1 || o_rs_addr !== '0)
      $display("FAIL async_reset: busy=%h ready=%b rs=%h want 00000000 1 0", o_busy_regs, o_input_ready, o_rs_addr);
    else n_pass++;
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_dual();
    test_wb_bypass();
    test_same_port();
    test_busy_stall();
    test_trap_flush();
    test_set_wins();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
